seq_magnitude_comparator: RTL

- Parametrised, multi-cycle successor to the team's 4-bit combinational magnitude comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per clock, with early termination on the first differing chunk.
- Supports signed (two's complement) and unsigned modes.
- Sits between a producer and a consumer with valid/ready handshakes on both sides; result flags are registered.

---
 rtl/seq_magnitude_comparator_if.sv | 30 +++
 rtl/seq_magnitude_comparator.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seq_magnitude_comparator_if.sv
// Handshake and result bundle for seq_magnitude_comparator.
// The producer drives operands (in_valid/a/b/signed_mode), the consumer
// drives out_ready, and the comparator drives everything else.
interface seq_magnitude_comparator_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             signed_mode;
   logic             out_valid;
   logic             out_ready;
   logic             A_eq_B;
   logic             A_gt_B;
   logic             A_lt_B;
   logic             busy;

   // Comparator side.
   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, A_eq_B, A_gt_B, A_lt_B, busy
   );

   // Producer/consumer side.
   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, A_eq_B, A_gt_B, A_lt_B, busy
   );
endinterface

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle magnitude comparator.
// Walks the operands MSB-first, CHUNK bits per clock, with optional early
// exit on the first differing chunk. Signed mode ranks the top chunk with
// its MSB inverted, which turns a two's complement order into an unsigned
// one for that chunk; lower chunks are always unsigned.
module seq_magnitude_comparator #(
   parameter int WIDTH      = 16,
   parameter int CHUNK      = 4,
   parameter int EARLY_EXIT = 1
) (
   input logic                       clk,
   input logic                       rst,
   seq_magnitude_comparator_if.slave bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCHUNK - 1);

   // Reject configurations where the operand cannot be split evenly.
   generate
      if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_cfg_err
         $error("seq_magnitude_comparator: WIDTH must be a non-zero multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             sign_q, sign_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             dec_gt_q, dec_gt_d;   // decision recorded while still walking
   logic             dec_lt_q, dec_lt_d;
   logic             eq_q, eq_d;           // registered result flags
   logic             gt_q, gt_d;
   logic             lt_q, lt_d;

   logic [CHUNK-1:0] chunk_a;
   logic [CHUNK-1:0] chunk_b;
   logic             decided;
   logic             hit_gt;
   logic             hit_lt;
   logic             finish;

   // Select the chunk under examination and rank it.
   // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      chunk_a = a_q[int'(idx_q) * CHUNK +: CHUNK];
      chunk_b = b_q[int'(idx_q) * CHUNK +: CHUNK];
      if (sign_q && (idx_q == TOP_IDX)) begin
         chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
         chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
      end
      decided = dec_gt_q | dec_lt_q;
      hit_gt  = dec_gt_q | (~decided & (chunk_a > chunk_b));
      hit_lt  = dec_lt_q | (~decided & (chunk_a < chunk_b));
      finish  = (idx_q == '0) || ((EARLY_EXIT != 0) && (hit_gt || hit_lt));
   end

   // Next-state and datapath control.
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      sign_d   = sign_q;
      idx_d    = idx_q;
      dec_gt_d = dec_gt_q;
      dec_lt_d = dec_lt_q;
      eq_d     = eq_q;
      gt_d     = gt_q;
      lt_d     = lt_q;

      case (state_q)
         S_IDLE: begin
            if (bus.in_valid) begin
               a_d      = bus.a;
               b_d      = bus.b;
               sign_d   = bus.signed_mode;
               idx_d    = TOP_IDX;
               dec_gt_d = 1'b0;
               dec_lt_d = 1'b0;
               eq_d     = 1'b0;
               gt_d     = 1'b0;
               lt_d     = 1'b0;
               state_d  = S_COMPARE;
            end
         end

         S_COMPARE: begin
            dec_gt_d = hit_gt;
            dec_lt_d = hit_lt;
            if (finish) begin
               gt_d    = hit_gt;
               lt_d    = hit_lt;
               eq_d    = ~(hit_gt | hit_lt);
               state_d = S_DONE;
            end else begin
               idx_d = idx_q - IDX_W'(1);
            end
         end

         S_DONE: begin
            if (bus.out_ready) begin
               eq_d    = 1'b0;
               gt_d    = 1'b0;
               lt_d    = 1'b0;
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Control state; reset drops any in-flight compare and its partial decision.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         dec_gt_q <= 1'b0;
         dec_lt_q <= 1'b0;
         eq_q     <= 1'b0;
         gt_q     <= 1'b0;
         lt_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         dec_gt_q <= dec_gt_d;
         dec_lt_q <= dec_lt_d;
         eq_q     <= eq_d;
         gt_q     <= gt_d;
         lt_q     <= lt_d;
      end
   end

   // Operand capture registers.
   // NOTE: data-only registers carry no reset; they are always loaded before the control path reads them.
   always_ff @(posedge clk) begin
      a_q    <= a_d;
      b_q    <= b_d;
      sign_q <= sign_d;
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.out_valid = (state_q == S_DONE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.A_eq_B    = eq_q;
   assign bus.A_gt_B    = gt_q;
   assign bus.A_lt_B    = lt_q;

endmodule
